// File: rtl/ssd_pkg.sv
// ==== ssd_pkg : shared constants and hex glyph table for the 7-segment scanner (rev 1.0) ====
`default_nettype none

package ssd_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int NUM_PHASES = 16;

  // Active-low segment patterns, bit0 = a ... bit6 = g, indexed by nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

`default_nettype wire

// File: rtl/ssd_hex_decoder.sv
// ==== ssd_hex_decoder : 4-bit nibble to active-low 7-segment glyph (rev 1.0) ====
`default_nettype none

module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

`default_nettype wire

// File: rtl/ssd_scan_controller.sv
// ==== ssd_scan_controller : multiplexed 7-segment scanner, PWM dimming, tear-free image load (rev 1.0) ====
`default_nettype none

module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_PERIOD = 100_000,
  parameter int BRIGHT_BITS  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_digits,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [NUM_DIGITS-1:0]   ssA,
  output logic [6:0]              ssC,
  output logic                    ssDP,
  output logic                    frame_done
);

  localparam int PHASE_LEN = DIGIT_PERIOD / NUM_PHASES;
  localparam int SUB_W     = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int XIDX_W    = $clog2(MAX_DIGITS);
  localparam int PAD_W     = 4 * MAX_DIGITS;

  // The slot prescaler is held as (phase, sub_cnt): phase advances every PHASE_LEN cycles.
  logic [SUB_W-1:0]        sub_cnt;
  logic [3:0]              phase;
  logic [IDX_W-1:0]        idx;
  logic [BRIGHT_BITS-1:0]  bright_q;
  logic                    pend_full;
  logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]   pend_dp, pend_blank, act_dp, act_blank;

  logic                    phase_end, slot_end, slot_start, idx_last, wrap;
  logic [BRIGHT_BITS-1:0]  bright_eff;
  logic [XIDX_W-1:0]       idx_ext;
  logic [PAD_W-1:0]        digits_pad;
  logic [MAX_DIGITS-1:0]   dp_pad, blank_pad;
  logic [3:0]              nib;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   anode_sel;

  assign phase_end  = (sub_cnt == SUB_W'(PHASE_LEN - 1));
  assign slot_end   = phase_end && (phase == 4'(NUM_PHASES - 1));
  assign slot_start = (sub_cnt == '0) && (phase == '0);
  assign idx_last   = (idx == IDX_W'(NUM_DIGITS - 1));
  assign wrap       = slot_end && idx_last;

  // Brightness is taken live on the first cycle of a slot and held for the rest of it.
  assign bright_eff = slot_start ? brightness : bright_q;

  assign idx_ext    = XIDX_W'(idx);
  assign digits_pad = PAD_W'(act_digits);
  assign dp_pad     = MAX_DIGITS'(act_dp);
  assign blank_pad  = MAX_DIGITS'(act_blank);
  assign nib        = digits_pad[4*idx_ext +: 4];
  assign anode_sel  = ~(NUM_DIGITS'(1) << idx);

  assign load_ready = ~pend_full;
  assign frame_done = wrap;

  ssd_hex_decoder u_dec (
    .nibble (nib),
    .seg    (seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_cnt     <= '0;
      phase       <= '0;
      idx         <= '0;
      bright_q    <= '0;
      pend_full   <= 1'b0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '1;
    end else begin
      sub_cnt <= phase_end ? '0 : sub_cnt + 1'b1;
      // 4-bit phase rolls 15 -> 0 on its own at the slot boundary.
      if (phase_end) phase <= phase + 1'b1;
      if (slot_end)  idx   <= idx_last ? '0 : idx + 1'b1;
      if (slot_start) bright_q <= brightness;

      if (wrap && pend_full) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
        act_blank  <= pend_blank;
        pend_full  <= 1'b0;
      end else if (load_valid && load_ready) begin
        pend_digits <= load_digits;
        pend_dp     <= load_dp;
        pend_blank  <= load_blank;
        pend_full   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ssA  <= '1;
      ssC  <= 7'h7F;
      ssDP <= 1'b1;
    end else if (!blank_pad[idx_ext]) begin
      ssA  <= (phase <= bright_eff) ? anode_sel : '1;
      ssC  <= seg;
      ssDP <= ~dp_pad[idx_ext];
    end else begin
      ssA  <= '1;
      ssC  <= 7'h7F;
      ssDP <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_controller.sv
// ==== tb_ssd_scan_controller : three scanner configurations against a cycle-count reference model (rev 1.0) ====
`default_nettype none

module tb_ssd_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        lv;
  logic [15:0] ld;
  logic [3:0]  ldp, lbl, br;

  logic [3:0] a0, a1;
  logic [0:0] a2;
  logic [6:0] c0, c1, c2;
  logic       dp0, dp1, dp2, r0, r1, r2, f0, f1, f2;

  always #5 clk = ~clk;

  ssd_scan_controller #(.NUM_DIGITS(4), .DIGIT_PERIOD(16), .BRIGHT_BITS(4)) dut0 (
    .clk(clk), .reset(rst), .load_valid(lv), .load_ready(r0), .load_digits(ld),
    .load_dp(ldp), .load_blank(lbl), .brightness(br), .ssA(a0), .ssC(c0),
    .ssDP(dp0), .frame_done(f0));

  ssd_scan_controller #(.NUM_DIGITS(4), .DIGIT_PERIOD(32), .BRIGHT_BITS(4)) dut1 (
    .clk(clk), .reset(rst), .load_valid(lv), .load_ready(r1), .load_digits(ld),
    .load_dp(ldp), .load_blank(lbl), .brightness(br), .ssA(a1), .ssC(c1),
    .ssDP(dp1), .frame_done(f1));

  ssd_scan_controller #(.NUM_DIGITS(1), .DIGIT_PERIOD(16), .BRIGHT_BITS(4)) dut2 (
    .clk(clk), .reset(rst), .load_valid(lv), .load_ready(r2), .load_digits(ld[3:0]),
    .load_dp(ldp[0]), .load_blank(lbl[0]), .brightness(br), .ssA(a2), .ssC(c2),
    .ssDP(dp2), .frame_done(f2));

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] on;
    case (n)  // active-high gfedcba
      4'h0: on = 7'b0111111;  4'h1: on = 7'b0000110;
      4'h2: on = 7'b1011011;  4'h3: on = 7'b1001111;
      4'h4: on = 7'b1100110;  4'h5: on = 7'b1101101;
      4'h6: on = 7'b1111101;  4'h7: on = 7'b0000111;
      4'h8: on = 7'b1111111;  4'h9: on = 7'b1101111;
      4'hA: on = 7'b1110111;  4'hB: on = 7'b1111100;
      4'hC: on = 7'b0111001;  4'hD: on = 7'b1011110;
      4'hE: on = 7'b1111001;  default: on = 7'b1110001;
    endcase
    return ~on;
  endfunction

  // Reference model: position in the frame is derived from cycles elapsed since reset.
  int          NN  [3] = '{4, 4, 1};
  int          DPP [3] = '{16, 32, 16};
  int          cyc [3];
  bit          pfull [3];
  logic [15:0] pdig [3], adig [3];
  logic [3:0]  pdp [3], pbl [3], adp [3], abl [3], bh [3], ea [3];
  logic [6:0]  ec [3];
  logic        edp [3], erdy [3], efd [3];
  bit          model_ok = 0;

  task automatic model_step(input int k);
    int n, dp, pos, idx, ph;
    logic [3:0] mask;
    n = NN[k]; dp = DPP[k];
    mask = (n == 4) ? 4'hF : 4'h1;
    if (rst) begin
      cyc[k] = 0; pfull[k] = 0; abl[k] = 4'hF; adig[k] = '0; adp[k] = '0;
      ea[k] = mask; ec[k] = 7'h7F; edp[k] = 1'b1; erdy[k] = 1'b1; efd[k] = 1'b0;
    end else begin
      pos = cyc[k] % dp;
      idx = (cyc[k] / dp) % n;
      ph  = pos / (dp / 16);
      if (pos == 0) bh[k] = br;
      if (!abl[k][idx]) begin
        ec[k]  = glyph(adig[k][idx*4 +: 4]);
        edp[k] = ~adp[k][idx];
        ea[k]  = (ph <= int'(bh[k])) ? (mask & ~(4'b0001 << idx)) : mask;
      end else begin
        ea[k] = mask; ec[k] = 7'h7F; edp[k] = 1'b1;
      end
      if (pos == dp - 1 && idx == n - 1 && pfull[k]) begin
        adig[k] = pdig[k]; adp[k] = pdp[k]; abl[k] = pbl[k]; pfull[k] = 0;
      end else if (!pfull[k] && lv) begin
        pdig[k] = ld; pdp[k] = ldp; pbl[k] = lbl; pfull[k] = 1;
      end
      cyc[k]++;
      erdy[k] = !pfull[k];
      efd[k]  = ((cyc[k] % dp) == dp - 1) && (((cyc[k] / dp) % n) == n - 1);
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    if (rst) model_ok = 1;
  end

  task automatic cmp(input int k, input logic [3:0] a, input logic [6:0] c,
                     input logic d, input logic r, input logic f);
    chk($sformatf("ssA[%0d]", k), a, ea[k]);
    chk($sformatf("ssC[%0d]", k), c, ec[k]);
    chk($sformatf("ssDP[%0d]", k), d, edp[k]);
    chk($sformatf("load_ready[%0d]", k), r, erdy[k]);
    chk($sformatf("frame_done[%0d]", k), f, efd[k]);
  endtask

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      cmp(0, a0, c0, dp0, r0, f0);
      cmp(1, a1, c1, dp1, r1, f1);
      cmp(2, {3'b000, a2}, c2, dp2, r2, f2);
    end
  end

  task automatic wait_fd0();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (f0 !== 1'b1 && n < 300);
    chk("frame_done0_timeout", (n < 300), 1);
  endtask

  logic [3:0] L_A  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] L_C  [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
  logic       L_DP [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int cnt0 [4], cnt1 [4];
  int cnt2, fd2n;

  initial begin
    rst = 1'b1; lv = 1'b0; ld = '0; ldp = '0; lbl = '0; br = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset_ssA", a0, 4'hF);
    chk("reset_ssC", c0, 7'h7F);
    chk("reset_ssDP", dp0, 1'b1);
    chk("reset_ready", r0, 1'b1);
    chk("reset_fd", f0, 1'b0);
    rst = 1'b0;

    // Basic scan: 12AF, dp on digit 1, full brightness.
    @(negedge clk);
    ld = 16'h12AF; ldp = 4'b0010; lbl = 4'b0000; lv = 1'b1;
    @(negedge clk);
    lv = 1'b0;
    wait_fd0();
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i % 16 == 10) begin
        chk("scan_ssA", a0, L_A[(i-10)/16]);
        chk("scan_ssC", c0, L_C[(i-10)/16]);
        chk("scan_ssDP", dp0, L_DP[(i-10)/16]);
      end
    end

    // PWM duty at brightness 3, plus single-digit frame rate.
    br = 4'd3;
    repeat (300) @(negedge clk);
    for (int j = 0; j < 4; j++) begin cnt0[j] = 0; cnt1[j] = 0; end
    cnt2 = 0; fd2n = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        if (i < 64 && !a0[j]) cnt0[j]++;
        if (!a1[j]) cnt1[j]++;
      end
      if (!a2[0]) cnt2++;
      if (f2) fd2n++;
    end
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("duty16_d%0d", j), cnt0[j], 4);
      chk($sformatf("duty32_d%0d", j), cnt1[j], 8);
    end
    chk("duty_n1", cnt2, 32);
    chk("fd_n1_count", fd2n, 8);

    // Image A mid-frame, then B held until the pending buffer frees up.
    wait_fd0();
    repeat (20) @(negedge clk);
    ld = 16'h3456; ldp = 4'b0000; lbl = 4'b0000; lv = 1'b1;
    @(negedge clk);
    ld = 16'h789B;
    chk("hold_ready_low", r0, 1'b0);
    wait_fd0();
    chk("commit_cycle_ready", r0, 1'b0);
    @(negedge clk);
    chk("post_commit_ready", r0, 1'b1);
    @(negedge clk);
    chk("b_accepted_ready", r0, 1'b0);
    chk("image_a_digit0", c0, 7'h02);
    lv = 1'b0;
    wait_fd0();
    repeat (2) @(negedge clk);
    chk("image_b_digit0", c0, 7'h03);

    // Blank digits 0 and 2.
    ld = 16'h4321; lbl = 4'b0101; ldp = 4'b1111; br = 4'hF; lv = 1'b1;
    @(negedge clk);
    lv = 1'b0;
    wait_fd0();
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i == 10 || i == 42) begin
        chk("blank_ssA", a0, 4'hF);
        chk("blank_ssC", c0, 7'h7F);
      end
      if (i == 26) begin chk("lit_d1_ssA", a0, 4'hD); chk("lit_d1_ssC", c0, 7'h24); end
      if (i == 58) begin chk("lit_d3_ssA", a0, 4'h7); chk("lit_d3_ssC", c0, 7'h19); end
    end

    // Reset with a full pending buffer while digit 2 is scanning.
    wait_fd0();
    @(negedge clk);
    ld = 16'hFFFF; lbl = 4'b0000; lv = 1'b1;
    @(negedge clk);
    lv = 1'b0;
    repeat (32) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_ssA", a0, 4'hF);
    chk("midreset_ssC", c0, 7'h7F);
    chk("midreset_ssDP", dp0, 1'b1);
    chk("midreset_ready", r0, 1'b1);
    chk("midreset_fd", f0, 1'b0);
    rst = 1'b0;
    wait_fd0();
    repeat (10) @(negedge clk);
    chk("dark_after_reset_ssA", a0, 4'hF);
    chk("dark_after_reset_ssC", c0, 7'h7F);
    ld = 16'h5555; lv = 1'b1;
    @(negedge clk);
    lv = 1'b0;
    wait_fd0();
    repeat (10) @(negedge clk);
    chk("relit_ssA", a0, 4'hE);
    chk("relit_ssC", c0, 7'h12);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      lv  = ($urandom % 6 == 0);
      ld  = 16'($urandom);
      ldp = 4'($urandom);
      lbl = 4'($urandom);
      if ($urandom % 40 == 0) br = 4'($urandom);
      rst = ($urandom % 700 == 0);
    end
    rst = 1'b0; lv = 1'b0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
